// File: rtl/occ_table_responder_pkg.sv
// Shared types and constants for the occurrence-table AXI4-Lite read responder.
package occ_table_responder_pkg;

    typedef logic [255:0] occ_line_t;
    typedef logic [1:0]   axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    localparam int unsigned OCC_LINE_BYTES = 32;
    localparam int unsigned OCC_LINE_SHIFT = $clog2(OCC_LINE_BYTES);

    typedef enum logic [0:0] {StWrIdle, StWrResp} wr_state_e;

endpackage

// File: rtl/occ_table_responder_fifo.sv
// Synchronous response FIFO with occupancy count; storage is not reset, only pointers and count.
module occ_resp_fifo #(
    parameter int unsigned Width = 258,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             valid_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_i && !do_pop) cnt_q <= cnt_q + CntW'(1);
            else if (!push_i && do_pop) cnt_q <= cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

    push_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !do_pop && (32'(cnt_q) == Depth)));

endmodule

// File: rtl/occ_table_responder.sv
// AXI4-Lite read-only responder serving 256-bit occurrence-table lines from on-chip RAM,
// with a host load port and credit-limited pipelined reads.
module occ_table_responder
    import occ_table_responder_pkg::*;
#(
    parameter int unsigned AW        = 40,
    parameter int unsigned DW        = 256,
    parameter int unsigned DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned MAX_OUTST = 4,
    localparam int unsigned IdxW     = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   s_axi_araddr_i,
    input  logic            s_axi_arvalid_i,
    output logic            s_axi_arready_o,
    output logic [DW-1:0]   s_axi_rdata_o,
    output logic [1:0]      s_axi_rresp_o,
    output logic            s_axi_rvalid_o,
    input  logic            s_axi_rready_i,
    input  logic [AW-1:0]   s_axi_awaddr_i,
    input  logic            s_axi_awvalid_i,
    output logic            s_axi_awready_o,
    input  logic [DW-1:0]   s_axi_wdata_i,
    input  logic [DW/8-1:0] s_axi_wstrb_i,
    input  logic            s_axi_wvalid_i,
    output logic            s_axi_wready_o,
    output logic [1:0]      s_axi_bresp_o,
    output logic            s_axi_bvalid_o,
    input  logic            s_axi_bready_i,
    input  logic            ld_we_i,
    input  logic [IdxW-1:0] ld_addr_i,
    input  logic [DW-1:0]   ld_data_i,
    output logic [31:0]     rd_done_cnt_o
);

    localparam int unsigned OffW = AW - OCC_LINE_SHIFT;
    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

    logic              live_q;
    logic [AW-1:0]     rel_addr;
    logic [OffW-1:0]   line_off;
    logic              in_range, ar_hs, r_hs, ld_ok;
    logic [RD_LAT-1:0] vld_q, ok_q;
    logic [DW-1:0]     ram_q [DEPTH];
    logic [DW-1:0]     dat_q [RD_LAT];
    logic              push;
    logic [DW+1:0]     push_data, head;
    logic              fifo_valid;
    logic [CntW-1:0]   fifo_cnt;
    int unsigned       outst;
    logic [31:0]       done_q;
    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_w_hs, bvalid;

    // Keeps the slave from accepting anything until the cycle after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) live_q <= 1'b0;
        else       live_q <= 1'b1;
    end

    assign rel_addr = s_axi_araddr_i - BASE_ADDR[AW-1:0];
    assign line_off = rel_addr[AW-1:OCC_LINE_SHIFT];
    assign in_range = (line_off < OffW'(DEPTH));

    if (DEPTH == (1 << IdxW)) begin : g_ld_pow2
        assign ld_ok = 1'b1;
    end else begin : g_ld_range
        assign ld_ok = (32'(ld_addr_i) < DEPTH);
    end

    // Read-first RAM; the read register is stage 0 of the data pipe.
    always_ff @(posedge clk_i) begin
        if (ld_we_i && ld_ok) ram_q[ld_addr_i] <= ld_data_i;
        if (ar_hs && in_range) dat_q[0] <= ram_q[line_off[IdxW-1:0]];
        for (int i = 1; i < RD_LAT; i++) dat_q[i] <= dat_q[i-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            ok_q  <= '0;
        end else begin
            vld_q[0] <= ar_hs;
            ok_q[0]  <= in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                ok_q[i]  <= ok_q[i-1];
            end
        end
    end

    assign push      = vld_q[RD_LAT-1];
    assign push_data = ok_q[RD_LAT-1] ? {RESP_OKAY, dat_q[RD_LAT-1]}
                                      : {RESP_DECERR, {DW{1'b0}}};

    occ_resp_fifo #(
        .Width (DW + 2),
        .Depth (MAX_OUTST)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (r_hs),
        .rdata_o (head),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    // Credit covers both the RAM pipe and the FIFO so a push always finds room.
    always_comb begin
        outst = 32'(fifo_cnt);
        for (int i = 0; i < RD_LAT; i++) outst += 32'(vld_q[i]);
    end

    assign s_axi_arready_o = live_q && (outst < MAX_OUTST);
    assign ar_hs           = s_axi_arvalid_i && s_axi_arready_o;
    assign s_axi_rvalid_o  = fifo_valid;
    assign s_axi_rdata_o   = fifo_valid ? head[DW-1:0] : '0;
    assign s_axi_rresp_o   = fifo_valid ? head[DW+:2] : RESP_OKAY;
    assign r_hs            = fifo_valid && s_axi_rready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     done_q <= '0;
        else if (r_hs) done_q <= done_q + 32'd1;
    end
    assign rd_done_cnt_o = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wr_state_q <= StWrIdle;
        else       wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_w_hs    = 1'b0;
        bvalid     = 1'b0;
        unique case (wr_state_q)
            StWrIdle: begin
                aw_w_hs = live_q && s_axi_awvalid_i && s_axi_wvalid_i;
                if (aw_w_hs) wr_state_d = StWrResp;
            end
            StWrResp: begin
                bvalid = 1'b1;
                if (s_axi_bready_i) wr_state_d = StWrIdle;
            end
            default: wr_state_d = StWrIdle;
        endcase
    end

    assign s_axi_awready_o = aw_w_hs;
    assign s_axi_wready_o  = aw_w_hs;
    assign s_axi_bvalid_o  = bvalid;
    assign s_axi_bresp_o   = RESP_SLVERR;

    logic unused_w;
    assign unused_w = ^{s_axi_awaddr_i, s_axi_wdata_i, s_axi_wstrb_i,
                        rel_addr[OCC_LINE_SHIFT-1:0], line_off[OffW-1:IdxW]};

endmodule

// File: tb/tb_occ_table_responder.sv
// Self-checking bench for occ_table_responder: random-data RAM image, queue-based read model.
module tb_occ_table_responder;
    import occ_table_responder_pkg::*;

    localparam int unsigned AW        = 40;
    localparam int unsigned DW        = 256;
    localparam int unsigned DEPTH     = 4096;
    localparam logic [63:0] BASE_ADDR = 64'd0;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned IdxW      = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0, arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid, rready = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0, awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic            wvalid = 1'b0, wready;
    logic [1:0]      bresp;
    logic            bvalid, bready = 1'b0;
    logic            ld_we = 1'b0;
    logic [IdxW-1:0] ld_addr = '0;
    logic [DW-1:0]   ld_data = '0;
    logic [31:0]     rd_done_cnt;

    always #5 clk = ~clk;

    occ_table_responder #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR),
        .RD_LAT(RD_LAT), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
        .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
        .s_axi_rready_i(rready),
        .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
        .s_axi_wready_o(wready),
        .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .rd_done_cnt_o(rd_done_cnt)
    );

    int checks = 0, errors = 0, cyc = 0, done_model = 0;
    logic [DW-1:0]   model_mem [DEPTH];
    logic [DW+1:0]   exp_q [$];
    logic            ar_hs, r_hs, r_vld, ar_rdy;
    logic [DW-1:0]   r_data;
    logic [1:0]      r_resp;
    logic            pend_ld_we = 1'b0;
    logic [IdxW-1:0] pend_ld_addr = '0;
    logic [DW-1:0]   pend_ld_data = '0;

    // Expected {resp, data} from byte-address arithmetic on the model image.
    function automatic logic [DW+1:0] model_read(input logic [AW-1:0] a);
        logic [AW-1:0]   rel;
        longint unsigned line;
        rel  = a - BASE_ADDR[AW-1:0];
        line = 64'(rel) / 64'(OCC_LINE_BYTES);
        if (line < 64'(DEPTH)) return {2'b00, model_mem[line]};
        return {2'b11, {DW{1'b0}}};
    endfunction

    function automatic logic [AW-1:0] line_addr(input int unsigned line);
        return BASE_ADDR[AW-1:0] + AW'(line) * AW'(OCC_LINE_BYTES);
    endfunction

    task automatic step(input logic arv, input logic [AW-1:0] ara, input logic rr);
        @(negedge clk);
        arvalid = arv; araddr = ara; rready = rr;
        ld_we = pend_ld_we; ld_addr = pend_ld_addr; ld_data = pend_ld_data;
        pend_ld_we = 1'b0;
        #1;
        ar_rdy = arready;
        ar_hs  = arvalid && arready;
        r_vld  = rvalid;
        r_hs   = rvalid && rready;
        r_data = rdata;
        r_resp = rresp;
        if (ar_hs) exp_q.push_back(model_read(ara));
        if (ld_we) model_mem[ld_addr] = ld_data;
        if (r_hs) done_model++;
        cyc++;
    endtask

    task automatic single_read(input logic [AW-1:0] a, output bit got,
                               output logic [DW-1:0] d, output logic [1:0] r,
                               output logic [DW+1:0] e);
        int n;
        got = 1'b0; d = '0; r = '0; e = '0;
        n = 0;
        step(1'b1, a, 1'b0);
        while (!ar_hs && n < 50) begin step(1'b1, a, 1'b0); n++; end
        if (!ar_hs) return;
        n = 0;
        step(1'b0, '0, 1'b1);
        while (!r_hs && n < 50) begin step(1'b0, '0, 1'b1); n++; end
        if (r_hs) begin
            got = 1'b1; d = r_data; r = r_resp;
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready got %b exp 0", arready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got %b exp 00", rresp); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if ({awready, wready} !== 2'b00) begin errors++; $display("FAIL reset_awready_wready got %b exp 00", {awready, wready}); end
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b exp 0", bvalid); end
        checks++; if (rd_done_cnt !== 32'd0) begin errors++; $display("FAIL reset_done_cnt got %0d exp 0", rd_done_cnt); end
        @(negedge clk); rst = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        checks++; if (ar_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_arready got %b exp 1", ar_rdy); end
    endtask

    task automatic preload();
        for (int i = 0; i < int'(DEPTH); i++) begin
            pend_ld_we = 1'b1; pend_ld_addr = IdxW'(i);
            for (int j = 0; j < int'(DW / 32); j++) pend_ld_data[j*32 +: 32] = $urandom();
            step(1'b0, '0, 1'b0);
        end
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_burst();
        int next = 0, got = 0, n = 0, first_ar = -1, last_ar = -1, first_rv = -1;
        logic [DW+1:0] e;
        for (int i = 0; i < 8; i++) begin
            pend_ld_we = 1'b1; pend_ld_addr = IdxW'(i); pend_ld_data = {8{32'(i)}};
            step(1'b0, '0, 1'b0);
        end
        while (got < 8 && n < 100) begin
            step(next < 8, line_addr(next), 1'b1);
            if (ar_hs) begin
                if (first_ar < 0) first_ar = cyc;
                last_ar = cyc; next++;
            end
            if (r_vld && first_rv < 0) first_rv = cyc;
            if (r_hs) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                checks++;
                if ({r_resp, r_data} !== e || r_data !== {8{32'(got)}}) begin
                    errors++;
                    $display("FAIL burst_beat%0d got %h/%h exp %h", got, r_resp, r_data, e);
                end
                got++;
            end
            n++;
        end
        checks++; if (got != 8) begin errors++; $display("FAIL burst_count got %0d exp 8", got); end
        checks++; if (first_rv - first_ar != int'(RD_LAT) + 1) begin
            errors++; $display("FAIL burst_latency got %0d exp %0d", first_rv - first_ar, RD_LAT + 1);
        end
        checks++; if (last_ar - first_ar != 7) begin
            errors++; $display("FAIL burst_back_to_back got span %0d exp 7", last_ar - first_ar);
        end
        step(1'b0, '0, 1'b0);
        checks++; if (rd_done_cnt !== 32'd8) begin errors++; $display("FAIL burst_done_cnt got %0d exp 8", rd_done_cnt); end
    endtask

    task automatic test_decode();
        bit got; logic [DW-1:0] d; logic [1:0] r; logic [DW+1:0] e;
        single_read(BASE_ADDR[AW-1:0] + AW'('h1f), got, d, r, e);
        checks++; if (!got || {r, d} !== {2'b00, {DW{1'b0}}} || {r, d} !== e) begin
            errors++; $display("FAIL unaligned_read got %0b %h/%h exp 00/0", got, r, d);
        end
        single_read(line_addr(DEPTH), got, d, r, e);
        checks++; if (!got || {r, d} !== {2'b11, {DW{1'b0}}} || {r, d} !== e) begin
            errors++; $display("FAIL decerr_read got %0b %h/%h exp 11/0", got, r, d);
        end
    endtask

    task automatic test_credit();
        int acc = 0, rcv = 0, n = 0, issued = 0;
        logic [AW-1:0] a;
        logic [DW+1:0] e;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, line_addr(i % 8), 1'b0);
            if (ar_hs) acc++;
        end
        checks++; if (acc != int'(MAX_OUTST)) begin errors++; $display("FAIL credit_accepted got %0d exp %0d", acc, MAX_OUTST); end
        checks++; if (ar_rdy !== 1'b0) begin errors++; $display("FAIL credit_arready_low got %b exp 0", ar_rdy); end
        while (rcv < int'(MAX_OUTST) && n < 30) begin
            step(1'b0, '0, 1'b1);
            if (r_hs) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                checks++;
                if ({r_resp, r_data} !== e) begin errors++; $display("FAIL credit_drain%0d got %h/%h exp %h", rcv, r_resp, r_data, e); end
                rcv++;
            end
            n++;
        end
        step(1'b0, '0, 1'b0);
        checks++; if (ar_rdy !== 1'b1 || rcv != int'(MAX_OUTST)) begin
            errors++; $display("FAIL credit_release got arready %b beats %0d exp 1 %0d", ar_rdy, rcv, MAX_OUTST);
        end
        rcv = 0; n = 0;
        a = line_addr($urandom_range(DEPTH - 1)) + AW'($urandom_range(31));
        while (rcv < 1000 && n < 20000) begin
            step(issued < 1000, a, ($urandom_range(3) == 0));
            if (ar_hs) begin
                issued++;
                if ($urandom_range(7) == 0) a = line_addr(DEPTH + $urandom_range(999));
                else a = line_addr($urandom_range(DEPTH - 1));
                a = a + AW'($urandom_range(31));
            end
            if (r_hs) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                checks++;
                if ({r_resp, r_data} !== e) begin errors++; $display("FAIL random_beat%0d got %h/%h exp %h", rcv, r_resp, r_data, e); end
                rcv++;
            end
            n++;
        end
        checks++; if (rcv != 1000 || exp_q.size() != 0) begin
            errors++; $display("FAIL random_total got %0d left %0d exp 1000 0", rcv, exp_q.size());
        end
    endtask

    task automatic test_write();
        bit got; logic [DW-1:0] d; logic [1:0] r; logic [DW+1:0] e;
        @(negedge clk); awaddr = AW'('h40); awvalid = 1'b1; wvalid = 1'b0; #1;
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL aw_without_w got %b exp 0", awready); end
        @(negedge clk); wvalid = 1'b1; wdata = {32{8'h55}}; #1;
        checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL aw_w_accept got %b exp 11", {awready, wready}); end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b10) begin errors++; $display("FAIL b_slverr got %b/%b exp 1/10", bvalid, bresp); end
        @(negedge clk); awvalid = 1'b1; wvalid = 1'b1; #1;
        checks++; if (bvalid !== 1'b1 || awready !== 1'b0) begin errors++; $display("FAIL b_hold got bvalid %b awready %b exp 1 0", bvalid, awready); end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk); bready = 1'b0; #1;
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL b_done got %b exp 0", bvalid); end
        single_read(AW'('h40), got, d, r, e);
        checks++; if (!got || {r, d} !== e || d === {32{8'h55}}) begin
            errors++; $display("FAIL write_no_effect got %h/%h exp %h", r, d, e);
        end
    endtask

    task automatic test_load_collision();
        bit got; logic [DW-1:0] d, old3; logic [1:0] r; logic [DW+1:0] e;
        old3 = model_mem[3];
        pend_ld_we = 1'b1; pend_ld_addr = IdxW'(3); pend_ld_data = {32{8'hAA}};
        single_read(AW'('h60), got, d, r, e);
        checks++; if (!got || d !== old3 || {r, d} !== e) begin
            errors++; $display("FAIL load_read_first got %h exp %h", d, old3);
        end
        single_read(AW'('h60), got, d, r, e);
        checks++; if (!got || d !== {32{8'hAA}} || r !== 2'b00) begin
            errors++; $display("FAIL load_new_data got %h/%h exp 00/aa..", r, d);
        end
    endtask

    task automatic test_reset_midflight();
        int acc = 0, n = 0;
        bit got; logic [DW-1:0] d; logic [1:0] r; logic [DW+1:0] e;
        while (acc < 3 && n < 20) begin
            step(1'b1, line_addr(acc), 1'b0);
            if (ar_hs) acc++;
            n++;
        end
        step(1'b0, '0, 1'b0);
        @(negedge clk); rst = 1'b1; arvalid = 1'b0; #1;
        checks++; if (rvalid !== 1'b0 || arready !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got rvalid %b arready %b exp 0 0", rvalid, arready);
        end
        checks++; if (rd_done_cnt !== 32'd0) begin errors++; $display("FAIL midreset_cnt got %0d exp 0", rd_done_cnt); end
        exp_q.delete();
        done_model = 0;
        @(negedge clk); rst = 1'b0;
        single_read(line_addr(1), got, d, r, e);
        checks++; if (!got || {r, d} !== {2'b00, {8{32'd1}}} || {r, d} !== e) begin
            errors++; $display("FAIL midreset_retained got %h/%h exp 00/%h", r, d, {8{32'd1}});
        end
        step(1'b0, '0, 1'b0);
        checks++; if (rd_done_cnt !== 32'd1) begin errors++; $display("FAIL midreset_cnt_after got %0d exp 1", rd_done_cnt); end
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload();
        test_burst();
        test_decode();
        test_credit();
        test_write();
        test_load_collision();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
